// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register and instruction-fetch stage.
// Drives an SRAM-like instruction bus, loads the IF/ID pipeline register,
// absorbs redirects that land while a fetch is outstanding and applies
// branch targets resolved in ID after the delay slot.
// Optional build macro IFETCH_STAT_EN adds the stat_fetch / stat_drop counters.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic        stallreq_if,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
`ifdef IFETCH_STAT_EN
  ,
  output logic [31:0] stat_fetch,
  output logic [31:0] stat_drop
`endif
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StHold
  } state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_br_pend;
  logic [31:0] r_br_target;
  logic [31:0] r_buf;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic        r_if_adel;

  state_e      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_buf_nxt;
  logic        w_br_pend_nxt;
  logic [31:0] w_br_target_nxt;
  logic [31:0] w_if_pc_nxt;
  logic [31:0] w_if_inst_nxt;
  logic        w_if_valid_nxt;
  logic        w_if_adel_nxt;

  logic        w_aligned;
  logic        w_fetch_hit;
  logic [31:0] w_fetch_data;
  logic        w_br_take;
  logic [31:0] w_next_pc;
  logic        w_deliver;
  logic [31:0] w_deliver_data;

  // stall[0] and stall[4:3] belong to other stages; only IF/ID and ID/EX matter here.
  logic w_unused_stall;
  assign w_unused_stall = ^{stall[4:3], stall[0]};

  // Bus-facing and pipeline-control outputs, all combinational from state and pc.
  always_comb begin
    w_aligned   = (r_pc[1:0] == 2'b00);
    ibus_req    = ((r_state == StFetch) || (r_state == StDrain)) && w_aligned;
    ibus_addr   = r_pc;
    stallreq_if = ((r_state == StFetch) && w_aligned && !ibus_ack) ||
                  ((r_state == StDrain) && !ibus_ack);
  end

  // Fetch result and sequential-next PC, with a same-cycle branch forwarded so
  // the instruction after the delay slot is the target.
  always_comb begin
    // A misaligned pc never goes to the bus: it completes at once with data 0.
    w_fetch_hit  = w_aligned ? ibus_ack : 1'b1;
    w_fetch_data = w_aligned ? ibus_rdata : 32'h0;
    w_br_take    = branch_flag && !stall[1] && !flush;
    if (w_br_take) begin
      w_next_pc = branch_target;
    end else if (r_br_pend) begin
      w_next_pc = r_br_target;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  // Fetch FSM next-state, PC and holding buffer.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_buf_nxt      = r_buf;
    w_deliver      = 1'b0;
    w_deliver_data = 32'h0;
    unique case (r_state)
      StIdle: begin
        w_state_nxt = StFetch;
      end
      StFetch: begin
        if (w_fetch_hit) begin
          if (flush) begin
            w_pc_nxt = new_pc;
          end else if (!stall[1]) begin
            w_deliver      = 1'b1;
            w_deliver_data = w_fetch_data;
            w_pc_nxt       = w_next_pc;
          end else begin
            w_buf_nxt   = w_fetch_data;
            w_state_nxt = StHold;
          end
        end else if (flush) begin
          // The old request is still owed a response; wait for it in DRAIN.
          w_pc_nxt    = new_pc;
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (flush) begin
          w_pc_nxt = new_pc;
        end
        if (ibus_ack) begin
          w_state_nxt = StFetch;
        end
      end
      StHold: begin
        if (flush) begin
          w_pc_nxt    = new_pc;
          w_state_nxt = StFetch;
        end else if (!stall[1]) begin
          w_deliver      = 1'b1;
          w_deliver_data = r_buf;
          w_pc_nxt       = w_next_pc;
          w_state_nxt    = StFetch;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Pending-branch bookkeeping: flush discards it, delivery consumes it.
  always_comb begin
    w_br_pend_nxt   = r_br_pend;
    w_br_target_nxt = r_br_target;
    if (flush || w_deliver) begin
      w_br_pend_nxt = 1'b0;
    end else if (w_br_take) begin
      w_br_pend_nxt   = 1'b1;
      w_br_target_nxt = branch_target;
    end
  end

  // IF/ID register next values: deliver, clear on flush, hold or bubble.
  always_comb begin
    w_if_pc_nxt    = r_if_pc;
    w_if_inst_nxt  = r_if_inst;
    w_if_valid_nxt = r_if_valid;
    w_if_adel_nxt  = r_if_adel;
    if (w_deliver) begin
      w_if_pc_nxt    = r_pc;
      w_if_inst_nxt  = w_deliver_data;
      w_if_valid_nxt = 1'b1;
      w_if_adel_nxt  = !w_aligned;
    end else if (flush) begin
      w_if_inst_nxt  = 32'h0;
      w_if_valid_nxt = 1'b0;
      w_if_adel_nxt  = 1'b0;
    end else if (!(stall[1] && stall[2])) begin
      // Bubble: ID is consuming (or advancing past) a slot we cannot fill.
      w_if_inst_nxt  = 32'h0;
      w_if_valid_nxt = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_br_pend   <= 1'b0;
      r_br_target <= 32'h0;
      r_buf       <= 32'h0;
      r_if_pc     <= 32'h0;
      r_if_inst   <= 32'h0;
      r_if_valid  <= 1'b0;
      r_if_adel   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_br_pend   <= w_br_pend_nxt;
      r_br_target <= w_br_target_nxt;
      r_buf       <= w_buf_nxt;
      r_if_pc     <= w_if_pc_nxt;
      r_if_inst   <= w_if_inst_nxt;
      r_if_valid  <= w_if_valid_nxt;
      r_if_adel   <= w_if_adel_nxt;
    end
  end

  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_valid = r_if_valid;
  assign if_adel  = r_if_adel;

`ifdef IFETCH_STAT_EN
  logic [31:0] r_stat_fetch;
  logic [31:0] r_stat_drop;
  logic        w_drop;

  // A response is thrown away when it lands during a redirect, drains a stale
  // request, or sits in the holding buffer when a flush arrives.
  assign w_drop = ((r_state == StFetch) && w_aligned && ibus_ack && flush) ||
                  ((r_state == StDrain) && ibus_ack) ||
                  ((r_state == StHold) && flush);

  // Delivered / dropped instruction counters, free-running with wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_fetch <= 32'h0;
      r_stat_drop  <= 32'h0;
    end else begin
      if (w_deliver) begin
        r_stat_fetch <= r_stat_fetch + 32'd1;
      end
      if (w_drop) begin
        r_stat_drop <= r_stat_drop + 32'd1;
      end
    end
  end

  assign stat_fetch = r_stat_fetch;
  assign stat_drop  = r_stat_drop;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scenarios followed by random stimulus, checked each
// cycle against a transaction-level reference model of the fetch stage.
module tb_ifetch_unit;
  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        stallreq_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_adel;
`ifdef IFETCH_STAT_EN
  logic [31:0] stat_fetch;
  logic [31:0] stat_drop;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .ibus_req     (ibus_req),
    .ibus_addr    (ibus_addr),
    .ibus_ack     (ibus_ack),
    .ibus_rdata   (ibus_rdata),
    .stallreq_if  (stallreq_if),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid),
    .if_adel      (if_adel)
`ifdef IFETCH_STAT_EN
    ,
    .stat_fetch   (stat_fetch),
    .stat_drop    (stat_drop)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Stimulus for the next cycle.
  logic [4:0]  s_stall = '0;
  logic        s_flush = 1'b0;
  logic [31:0] s_new_pc = '0;
  logic        s_br = 1'b0;
  logic [31:0] s_br_tgt = '0;

  // Reference model: what the fetch stage has promised, not how it is built.
  bit          m_started = 0;   // first fetch begun after reset
  bit          m_stale = 0;     // a bus response is owed but belongs to a dead path
  bit          m_have_buf = 0;  // a fetched word waits for ID to accept it
  logic [31:0] m_buf = '0;
  bit          m_br_valid = 0;
  logic [31:0] m_br_t = '0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_if_pc = '0;
  logic [31:0] m_if_inst = '0;
  logic        m_if_valid = 1'b0;
  logic        m_if_adel = 1'b0;
  logic [31:0] m_nfetch = '0;
  logic [31:0] m_ndrop = '0;

  // Bus slave: answers each request once after 1..3 cycles.
  bit          sl_busy = 0;
  int          sl_cnt = 0;
  logic [31:0] sl_addr = '0;
  int          fixed_lat = 0;
  bit          sl_poison = 0;
  logic [31:0] last_start = '0;

  // Observed deliveries into ID.
  logic [31:0] dlog[$];
  bit          prev_s1 = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance model and slave.
  task automatic step();
    logic        ack;
    logic [31:0] rd;
    logic        aligned;
    logic        got;
    logic        deliver;
    logic        s1;
    logic        s2;
    logic [31:0] gdata;
    ack = sl_busy && (sl_cnt == 1);
    rd  = ack ? (sl_poison ? 32'hDEADBEEF : mem_word(sl_addr)) : $urandom;
    stall         = s_stall;
    flush         = s_flush;
    new_pc        = s_new_pc;
    branch_flag   = s_br;
    branch_target = s_br_tgt;
    ibus_ack      = ack;
    ibus_rdata    = rd;
    @(negedge clk);
    aligned = (m_pc[1:0] == 2'b00);
    chk32("ibus_req", ibus_req, m_started && !m_have_buf && aligned);
    chk32("ibus_addr", ibus_addr, m_pc);
    chk32("stallreq_if", stallreq_if, m_started && !m_have_buf && !ack && (aligned || m_stale));
    chk32("if_pc", if_pc, m_if_pc);
    chk32("if_inst", if_inst, m_if_inst);
    chk32("if_valid", if_valid, m_if_valid);
    chk32("if_adel", if_adel, m_if_adel);
`ifdef IFETCH_STAT_EN
    chk32("stat_fetch", stat_fetch, m_nfetch);
    chk32("stat_drop", stat_drop, m_ndrop);
`endif
    if (!prev_s1 && if_valid === 1'b1) dlog.push_back(if_pc);

    s1 = s_stall[1];
    s2 = s_stall[2];
    got = 0;
    gdata = '0;
    if (m_started && !m_stale) begin
      if (m_have_buf) begin
        got = 1; gdata = m_buf;
      end else if (!aligned) begin
        got = 1; gdata = '0;
      end else if (ack) begin
        got = 1; gdata = rd;
      end
    end
    deliver = got && !s_flush && !s1;
    if (m_started) begin
      if (m_stale && ack) m_ndrop++;
      else if (!m_stale && !m_have_buf && aligned && ack && s_flush) m_ndrop++;
      else if (m_have_buf && s_flush) m_ndrop++;
    end
    if (deliver) m_nfetch++;

    if (deliver) begin
      m_if_pc = m_pc; m_if_inst = gdata; m_if_valid = 1'b1; m_if_adel = !aligned;
    end else if (s_flush) begin
      m_if_inst = '0; m_if_valid = 1'b0; m_if_adel = 1'b0;
    end else if (!(s1 && s2)) begin
      m_if_inst = '0; m_if_valid = 1'b0;
    end

    if (!m_started) begin
      m_started = 1;
    end else if (s_flush) begin
      m_stale    = !m_have_buf && (m_stale || aligned) && !ack;
      m_have_buf = 0;
      m_pc       = s_new_pc;
    end else if (m_stale) begin
      if (ack) m_stale = 0;
    end else if (deliver) begin
      if (s_br) m_pc = s_br_tgt;          // branch resolved while its delay slot lands
      else if (m_br_valid) m_pc = m_br_t;
      else m_pc = m_pc + 32'd4;
      m_have_buf = 0;
    end else if (got) begin
      m_have_buf = 1; m_buf = gdata;
    end

    if (s_flush || deliver) m_br_valid = 0;
    else if (s_br && !s1) begin
      m_br_valid = 1; m_br_t = s_br_tgt;
    end

    if (sl_busy) begin
      if (ack) begin
        sl_busy = 0; sl_poison = 0;
      end else begin
        sl_cnt--;
      end
    end else if (ibus_req === 1'b1) begin
      sl_busy    = 1;
      sl_cnt     = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
      sl_addr    = ibus_addr;
      last_start = ibus_addr;
    end
    prev_s1 = s1;
    @(posedge clk);
    #1;
  endtask

  // Advance until the slave is 'cnt' cycles from its ack, bounded.
  task automatic wait_slave(input int cnt, input string tag);
    for (int i = 0; i < 20; i++) begin
      if (sl_busy && sl_cnt == cnt) break;
      step();
    end
    chk32(tag, sl_busy && sl_cnt == cnt, 1);
  endtask

  initial begin
    int          n0;
    int          hits;
    logic [31:0] slot;
    logic [31:0] hpc;
    logic [31:0] tmp;

    rst = 1'b1; stall = '0; flush = 0; new_pc = '0; branch_flag = 0;
    branch_target = '0; ibus_ack = 0; ibus_rdata = '0;
    @(negedge clk);
    chk32("rst_req", ibus_req, 0);
    chk32("rst_stallreq", stallreq_if, 0);
    chk32("rst_if_valid", if_valid, 0);
    chk32("rst_if_pc", if_pc, 0);
    chk32("rst_if_inst", if_inst, 0);
    chk32("rst_if_adel", if_adel, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency-2 fetches from the reset vector.
    fixed_lat = 2;
    for (int i = 0; i < 10; i++) step();
    chk32("first_two_deliveries", dlog.size() >= 2, 1);
    if (dlog.size() >= 2) begin
      chk32("first_if_pc", dlog[0], 32'hBFC00000);
      chk32("second_if_pc", dlog[1], 32'hBFC00004);
    end

    // Fastest responder.
    fixed_lat = 1;
    n0 = dlog.size();
    for (int i = 0; i < 9; i++) step();
    chk32("fast_deliveries", dlog.size() >= n0 + 4, 1);
    if (dlog.size() >= n0 + 4) chk32("fast_seq", dlog[n0 + 3] - dlog[n0], 32'd12);

    // Redirect while a fetch is outstanding; its late data must be discarded.
    fixed_lat = 3;
    wait_slave(3, "wait_outstanding");
    sl_poison = 1;
    s_flush = 1; s_new_pc = 32'hBFC00380;
    step();
    s_flush = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      assert (if_inst !== 32'hDEADBEEF)
      else begin
        errors++;
        $error("FAIL stale_data: observed %h expected not deadbeef", if_inst);
      end
    end
    chk32("redirect_addr", last_start & 32'hFFFF_FFF0, 32'hBFC00380);
`ifdef IFETCH_STAT_EN
    chk32("stat_drop_one", stat_drop, 1);
`endif

    // Branch resolved while its delay slot is being fetched.
    fixed_lat = 2;
    wait_slave(2, "wait_slot");
    slot = sl_addr;
    s_br = 1; s_br_tgt = 32'h80001000;
    step();
    s_br = 0;
    n0 = dlog.size();
    for (int i = 0; i < 10; i++) step();
    chk32("branch_deliveries", dlog.size() >= n0 + 2, 1);
    if (dlog.size() >= n0 + 2) begin
      chk32("delay_slot_pc", dlog[n0], slot);
      chk32("branch_tgt_pc", dlog[n0 + 1], 32'h80001000);
    end

    // Stall IF/ID and ID/EX as the response arrives; deliver exactly once.
    wait_slave(1, "wait_ack");
    hpc = sl_addr;
    s_stall = 5'b00111;
    for (int i = 0; i < 3; i++) step();
    s_stall = '0;
    n0 = dlog.size();
    for (int i = 0; i < 6; i++) step();
    hits = 0;
    for (int i = n0; i < dlog.size(); i++) if (dlog[i] == hpc) hits++;
    chk32("held_once", hits, 1);

    // Misaligned redirect: no bus request, address-error delivered next edge.
    fixed_lat = 1;
    wait_slave(1, "wait_ack2");
    s_flush = 1; s_new_pc = 32'h80000002;
    step();
    s_flush = 0;
    chk32("adel_no_req", ibus_req, 0);
    step();
    chk32("adel_flag", if_adel, 1);
    chk32("adel_inst", if_inst, 0);
    chk32("adel_pc", if_pc, 32'h80000002);
    chk32("adel_valid", if_valid, 1);
    s_flush = 1; s_new_pc = 32'h80000000;
    step();
    s_flush = 0;

    // Random traffic.
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      s_stall    = 5'($urandom);
      s_stall[1] = ($urandom_range(0, 3) == 0);
      s_flush    = ($urandom_range(0, 19) == 0);
      tmp        = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 7) == 0) tmp[1:0] = 2'($urandom_range(1, 3));
      s_new_pc   = tmp;
      s_br       = ($urandom_range(0, 9) == 0);
      tmp        = 32'h9000_0000 | ($urandom & 32'h0000_FFFC);
      if ($urandom_range(0, 15) == 0) tmp[1:0] = 2'($urandom_range(1, 3));
      s_br_tgt   = tmp;
      step();
    end
    s_stall = '0; s_flush = 0; s_br = 0;
    step();

    // Asynchronous reset takes effect without a clock edge.
    rst = 1'b1;
    #1;
    chk32("async_rst_req", ibus_req, 0);
    chk32("async_rst_stallreq", stallreq_if, 0);
    chk32("async_rst_valid", if_valid, 0);
    chk32("async_rst_pc", if_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- PC and instruction-fetch stage of the MIPS pipeline, sitting directly downstream of the pipeline control block.
- Consumes stall[4:0], flush and new_pc from that control block, and returns stallreq bit 0 to it.
- Owns the PC, drives an SRAM-like instruction bus, and loads the IF/ID pipeline register (if_pc, if_inst, if_valid, if_adel).
- Handles exception redirects that arrive while a fetch is outstanding, and branch targets produced in ID.

Parameters:
- RESET_PC, 32'hBFC00000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  5  per-stage stall vector from pipeline control; bit0 = PC, bit1 = IF/ID, bit2 = ID/EX.
- flush  in  1  exception/ERET redirect.
- new_pc  in  32  redirect target, valid when flush=1.
- branch_flag  in  1  ID resolved a taken branch/jump.
- branch_target  in  32  target for branch_flag.
- ibus_req  out  1  instruction-bus request.
- ibus_addr  out  32  word address, equals pc.
- ibus_ack  in  1  single-cycle response pulse; earliest one cycle after req rises.
- ibus_rdata  in  32  instruction, valid with ack.
- stallreq_if  out  1  fetch-not-ready; wired to stallreq[0].
- if_pc  out  32  IF/ID register: PC of delivered instruction.
- if_inst  out  32  IF/ID register: instruction word.
- if_valid  out  1  IF/ID register: slot holds a real instruction.
- if_adel  out  1  IF/ID register: fetch address misaligned.

Behaviour:
- Reset (asynchronous): pc=RESET_PC, state=IDLE, br_pend=0, buf=0, if_pc=0, if_inst=0, if_valid=0, if_adel=0. ibus_req=0 and stallreq_if=0 while rst=1.
- ibus_req is combinational: 1 when state∈{FETCH,DRAIN} and pc[1:0]==0.
- ibus_addr = pc. It is held stable while req is high and no ack has arrived.
- stallreq_if is combinational: (FETCH and aligned and !ibus_ack) or (DRAIN and !ibus_ack).
- States:
  - IDLE→FETCH on the first clock after reset deasserts.
  - FETCH:
    - ack and flush: drop data; pc<=new_pc; stay in FETCH.
    - ack, no flush, stall[1]=0: deliver rdata; pc<=next; stay in FETCH (back-to-back request next cycle).
    - ack, no flush, stall[1]=1: buf<=rdata; go to HOLD.
    - no ack and flush: pc<=new_pc; go to DRAIN.
  - DRAIN (stale request still on bus):
    - ack: drop data; go to FETCH with the current pc.
    - flush again: pc<=new_pc; stay in DRAIN.
  - HOLD:
    - flush: drop buf; pc<=new_pc; go to FETCH.
    - else if stall[1]=0: deliver buf; pc<=next; go to FETCH.
- Misaligned pc in FETCH: no bus request. Behaves as an immediate ack with data 0; delivery sets if_adel=1, if_inst=0.
- Deliver means: if_pc<=pc, if_inst<=data, if_valid<=1, if_adel<=(pc[1:0]!=0).
- IF/ID register update when not delivering:
  - flush: if_valid<=0, if_inst<=0, if_adel<=0.
  - stall[1]=1 and stall[2]=0: bubble (if_valid<=0, if_inst<=0).
  - stall[1]=1 and stall[2]=1: hold.
  - stall[1]=0 with no data available: bubble.
- Branch handling:
  - next = br_pend ? br_target : pc+4, with 32-bit wrap.
  - branch_flag is sampled only when stall[1]=0: br_pend<=1, br_target<=branch_target.
  - The delay-slot instruction is the fetch in progress, so no discard is needed.
  - br_pend clears on delivery that consumes it, and on flush.
- Priority: rst > flush > branch capture > normal sequencing.
- flush and branch_flag in the same cycle: flush wins and the branch is discarded.

Optional Feature:
- Macro: IFETCH_STAT_EN.
- Defined: adds outputs stat_fetch (32, counts delivered instructions) and stat_drop (32, counts responses discarded in FETCH-with-flush, DRAIN or HOLD-with-flush). Both reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=BFC00000, ack 2 cycles after req -> first ibus_addr=BFC00000; stallreq_if=1 until ack; if_pc=BFC00000 with if_valid=1; next ibus_addr=BFC00004.
- Ack on every cycle after req, 4 fetches -> if_pc sequence BFC00000/04/08/0C, no bubbles, stallreq_if=0 on ack cycles.
- flush with new_pc=BFC00380 while fetch outstanding, ack 3 cycles later with 0xDEADBEEF -> DEADBEEF never appears in if_inst; next ibus_addr=BFC00380; stat_drop=1 when IFETCH_STAT_EN is defined.
- branch_flag with target 80001000 while the delay slot at pc=BFC00008 is fetching -> delivered if_pc order BFC00008, 80001000.
- stall=5'b00111 when ack arrives, released after 3 cycles -> state HOLD; IF/ID held; instruction delivered on the first cycle with stall[1]=0, exactly once.
- Redirect new_pc=80000002 -> ibus_req stays 0; if_adel=1, if_inst=0, if_pc=80000002 delivered the next edge.
